adc_burst_packer: RTL and testbench

Packs the 32-bit tagged ADC sample stream into 64-bit beats and buffers them in a FIFO. Emits bursts of at most BURST_LEN beats, each closed by tlast, to the downstream DMA writer. Sits directly downstream of the ADC capture stage, which has no backpressure. Absorbs writer stalls and reports overflow and tag errors.

---
 rtl/adc_burst_packer.sv | 117 +++++++++++
 tb/tb_adc_burst_packer.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/adc_burst_packer.sv
// adc_burst_packer: packs tagged 32-bit ADC words into 64-bit beats, buffers them in a FIFO
// and emits tlast-bounded bursts, counting overflow drops and tag errors.
module adc_burst_packer #(
  parameter int FIFO_AW   = 9,
  parameter int BURST_LEN = 16
) (
  input  logic               aclk,
  input  logic               aresetn,
  input  logic               flush,
  input  logic               clr_status,
  input  logic               s_axis_tvalid,
  input  logic [31:0]        s_axis_tdata,
  input  logic               s_axis_tlast,
  output logic               m_axis_tvalid,
  input  logic               m_axis_tready,
  output logic [63:0]        m_axis_tdata,
  output logic               m_axis_tlast,
  output logic [FIFO_AW:0]   fifo_level,
  output logic               overflow,
  output logic [15:0]        overflow_count,
  output logic [15:0]        tag_errors,
  output logic [31:0]        packets_done
);
  localparam int CW = FIFO_AW + 1;
  localparam int BW = $clog2(BURST_LEN);
  localparam logic [FIFO_AW:0] DEPTH = {1'b1, {FIFO_AW{1'b0}}};
  typedef enum logic [1:0] {EVEN, HALF, DISCARD} state_t;
  state_t state_q, state_d;
  logic [31:0] held_q, held_d;
  logic [64:0] mem [0:(1<<FIFO_AW)-1];
  logic [FIFO_AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [FIFO_AW:0] cnt_q, cnt_d;
  logic [BW-1:0] burst_q, burst_d;
  logic vld_q, vld_d, last_q, last_d, elast_q, elast_d;
  logic [63:0] data_q, data_d;
  logic [15:0] ovf_cnt_q, ovf_cnt_d, tag_q, tag_d;
  logic ovf_q, ovf_d;
  logic [31:0] pkt_q, pkt_d;
  logic beat, full, pop, push_req, push_ok, drop, tag_err;
  logic [64:0] push_ent, head;
  logic [1:0] ovf_inc;
  logic [16:0] ovf_sum, tag_sum;
  always_comb begin
    beat     = s_axis_tvalid & s_axis_tdata[31] & ~flush;
    tag_err  = s_axis_tvalid & ~flush & (~s_axis_tdata[31] | (s_axis_tdata[30] ^ s_axis_tlast));
    full     = cnt_q == DEPTH;
    pop      = vld_q & m_axis_tready;
    push_req = beat & (state_q == HALF | (state_q == EVEN & s_axis_tlast));
    push_ent = state_q == HALF ? {s_axis_tlast, s_axis_tdata, held_q} : {1'b1, 32'h0, s_axis_tdata};
    push_ok  = push_req & ~full;
    drop     = push_req & full;
    ovf_inc  = drop ? (state_q == HALF ? 2'd2 : 2'd1) : {1'b0, beat & state_q == DISCARD};
    state_d  = flush ? EVEN : ~beat ? state_q :
               state_q == EVEN ? (s_axis_tlast ? EVEN : HALF) :
               state_q == HALF ? (drop & ~s_axis_tlast ? DISCARD : EVEN) :
               (s_axis_tlast ? EVEN : DISCARD);
    held_d   = beat & state_q == EVEN & ~s_axis_tlast ? s_axis_tdata : held_q;
    wr_d     = flush ? '0 : wr_q + FIFO_AW'(push_ok);
    rd_d     = flush ? '0 : rd_q + FIFO_AW'(pop);
    cnt_d    = flush ? '0 : cnt_q + CW'(push_ok) - CW'(pop);
    // Presentation lags the push by one cycle: only entries already counted are exposed.
    vld_d    = ~flush & ((cnt_q - CW'(pop)) != '0);
    burst_d  = flush ? '0 : pop ? (last_q ? '0 : burst_q + BW'(1)) : burst_q;
    head     = mem[rd_d];
    data_d   = vld_d ? head[63:0] : data_q;
    elast_d  = vld_d ? head[64] : elast_q;
    last_d   = vld_d ? (head[64] | burst_d == BW'(BURST_LEN - 1)) : last_q;
    ovf_sum  = {1'b0, ovf_cnt_q} + 17'(ovf_inc);
    tag_sum  = {1'b0, tag_q} + 17'(tag_err);
    ovf_cnt_d = clr_status ? '0 : ovf_sum[16] ? 16'hFFFF : ovf_sum[15:0];
    tag_d     = clr_status ? '0 : tag_sum[16] ? 16'hFFFF : tag_sum[15:0];
    ovf_d     = ~clr_status & (ovf_q | ovf_inc != 2'd0);
    pkt_d     = pkt_q + 32'(pop & elast_q);
  end
  always_ff @(posedge aclk)
    if (push_ok) mem[wr_q] <= push_ent;
  always_ff @(posedge aclk or negedge aresetn)
    if (!aresetn) begin
      state_q   <= EVEN;
      held_q    <= '0;
      wr_q      <= '0;
      rd_q      <= '0;
      cnt_q     <= '0;
      burst_q   <= '0;
      vld_q     <= 1'b0;
      last_q    <= 1'b0;
      elast_q   <= 1'b0;
      data_q    <= '0;
      ovf_cnt_q <= '0;
      tag_q     <= '0;
      ovf_q     <= 1'b0;
      pkt_q     <= '0;
    end else begin
      state_q   <= state_d;
      held_q    <= held_d;
      wr_q      <= wr_d;
      rd_q      <= rd_d;
      cnt_q     <= cnt_d;
      burst_q   <= burst_d;
      vld_q     <= vld_d;
      last_q    <= last_d;
      elast_q   <= elast_d;
      data_q    <= data_d;
      ovf_cnt_q <= ovf_cnt_d;
      tag_q     <= tag_d;
      ovf_q     <= ovf_d;
      pkt_q     <= pkt_d;
    end
  assign m_axis_tvalid  = vld_q;
  assign m_axis_tdata   = data_q;
  assign m_axis_tlast   = last_q;
  assign fifo_level     = cnt_q;
  assign overflow       = ovf_q;
  assign overflow_count = ovf_cnt_q;
  assign tag_errors     = tag_q;
  assign packets_done   = pkt_q;
endmodule

// File: tb/tb_adc_burst_packer.sv
// tb_adc_burst_packer: directed checks of packing, bursts, overflow, tag errors and flush.
module tb_adc_burst_packer;
  logic aclk = 0, aresetn = 0, flush = 0, clr_status = 0;
  logic s_axis_tvalid = 0, s_axis_tlast = 0, m_axis_tready = 0;
  logic [31:0] s_axis_tdata = 0;
  logic m_axis_tvalid, m_axis_tlast, overflow;
  logic [63:0] m_axis_tdata;
  logic [2:0] fifo_level;
  logic [15:0] overflow_count, tag_errors;
  logic [31:0] packets_done;
  int total = 0, bad = 0;
  logic [64:0] q[$];
  adc_burst_packer #(.FIFO_AW(2), .BURST_LEN(16)) dut (
    .aclk(aclk), .aresetn(aresetn), .flush(flush), .clr_status(clr_status),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tdata(s_axis_tdata), .s_axis_tlast(s_axis_tlast),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready), .m_axis_tdata(m_axis_tdata),
    .m_axis_tlast(m_axis_tlast), .fifo_level(fifo_level), .overflow(overflow),
    .overflow_count(overflow_count), .tag_errors(tag_errors), .packets_done(packets_done)
  );
  always #5 aclk = ~aclk;
  always @(negedge aclk)
    if (m_axis_tvalid && m_axis_tready) q.push_back({m_axis_tlast, m_axis_tdata});
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic step;
    @(posedge aclk);
    #1;
  endtask
  task automatic send(input logic [31:0] w, input logic l);
    s_axis_tvalid = 1;
    s_axis_tdata = w;
    s_axis_tlast = l;
    step();
    s_axis_tvalid = 0;
    s_axis_tlast = 0;
  endtask
  task automatic drain(input string tag, input int n);
    int k = 0;
    while (q.size() < n && k < 300) begin
      step();
      k++;
    end
    repeat (4) step();
    chk({tag, "_nbeats"}, 64'(q.size()), 64'(n));
  endtask
  task automatic expect_beat(input string tag, input logic [63:0] d, input logic l);
    logic [64:0] b;
    chk({tag, "_present"}, 64'(q.size() != 0), 64'd1);
    if (q.size() != 0) begin
      b = q.pop_front();
      chk(tag, b[63:0], d);
      chk({tag, "_tlast"}, 64'(b[64]), 64'(l));
    end
  endtask
  initial begin
    repeat (3) step();
    aresetn = 1;
    step();
    chk("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
    chk("rst_tdata", m_axis_tdata, 64'd0);
    chk("rst_tlast", 64'(m_axis_tlast), 64'd0);
    chk("rst_level", 64'(fifo_level), 64'd0);
    chk("rst_ovf", 64'(overflow), 64'd0);
    chk("rst_ovf_cnt", 64'(overflow_count), 64'd0);
    chk("rst_tag", 64'(tag_errors), 64'd0);
    chk("rst_pkts", 64'(packets_done), 64'd0);
    // four-word packet with latency probes
    m_axis_tready = 1;
    send(32'h8000_0001, 0);
    send(32'h8000_0002, 0);
    chk("lat_n1_tvalid", 64'(m_axis_tvalid), 64'd0);
    chk("lat_n1_level", 64'(fifo_level), 64'd1);
    send(32'h8000_0003, 0);
    chk("lat_n2_tvalid", 64'(m_axis_tvalid), 64'd1);
    chk("lat_n2_tdata", m_axis_tdata, 64'h8000_0002_8000_0001);
    send(32'hC000_0004, 1);
    drain("pkt4", 2);
    expect_beat("pkt4_b1", 64'h8000_0002_8000_0001, 0);
    expect_beat("pkt4_b2", 64'hC000_0004_8000_0003, 1);
    chk("pkt4_pkts", 64'(packets_done), 64'd1);
    // odd-length packet pads the upper half
    send(32'h8000_0001, 0);
    send(32'h8000_0002, 0);
    send(32'hC000_0003, 1);
    drain("pkt3", 2);
    expect_beat("pkt3_b1", 64'h8000_0002_8000_0001, 0);
    expect_beat("pkt3_b2", 64'h0000_0000_C000_0003, 1);
    chk("pkt3_pkts", 64'(packets_done), 64'd2);
    // 64-word packet splits into two 16-beat bursts
    for (int i = 1; i <= 64; i++) send((i == 64 ? 32'hC000_0000 : 32'h8000_0000) | 32'(i), i == 64);
    drain("burst", 32);
    for (int k = 1; k <= 32; k++)
      expect_beat($sformatf("burst_b%0d", k),
                  {(k == 32 ? 32'hC000_0000 : 32'h8000_0000) | 32'(2 * k), 32'h8000_0000 | 32'(2 * k - 1)},
                  k == 16 || k == 32);
    chk("burst_pkts", 64'(packets_done), 64'd3);
    // overflow into a 4-entry FIFO with the writer stalled
    m_axis_tready = 0;
    for (int i = 1; i <= 20; i++) send((i == 20 ? 32'hC000_0000 : 32'h8000_0000) | 32'(i), i == 20);
    chk("ovf_level", 64'(fifo_level), 64'd4);
    chk("ovf_flag", 64'(overflow), 64'd1);
    chk("ovf_cnt", 64'(overflow_count), 64'd12);
    chk("ovf_hold_tvalid", 64'(m_axis_tvalid), 64'd1);
    chk("ovf_hold_tdata", m_axis_tdata, 64'h8000_0002_8000_0001);
    m_axis_tready = 1;
    drain("ovf", 4);
    for (int k = 1; k <= 4; k++)
      expect_beat($sformatf("ovf_b%0d", k), {32'h8000_0000 | 32'(2 * k), 32'h8000_0000 | 32'(2 * k - 1)}, 0);
    send(32'h8000_0011, 0);
    send(32'hC000_0012, 1);
    drain("post_ovf", 1);
    expect_beat("post_ovf_b1", 64'hC000_0012_8000_0011, 1);
    chk("post_ovf_cnt", 64'(overflow_count), 64'd12);
    chk("post_ovf_pkts", 64'(packets_done), 64'd4);
    clr_status = 1;
    step();
    clr_status = 0;
    chk("clr_ovf", 64'(overflow), 64'd0);
    chk("clr_ovf_cnt", 64'(overflow_count), 64'd0);
    // tag errors: untagged beat dropped, last-tag mismatch kept
    send(32'h8000_0021, 0);
    send(32'h0000_1234, 0);
    send(32'h8000_0022, 0);
    send(32'h8000_0005, 1);
    drain("tag", 2);
    expect_beat("tag_b1", 64'h8000_0022_8000_0021, 0);
    expect_beat("tag_b2", 64'h0000_0000_8000_0005, 1);
    chk("tag_cnt", 64'(tag_errors), 64'd2);
    clr_status = 1;
    send(32'h0000_0777, 0);
    clr_status = 0;
    chk("clr_with_inc", 64'(tag_errors), 64'd0);
    // flush in HALF with three entries queued, racing an input word
    m_axis_tready = 0;
    for (int i = 1; i <= 7; i++) send(32'h8000_0040 | 32'(i), 0);
    chk("pre_flush_level", 64'(fifo_level), 64'd3);
    flush = 1;
    send(32'h8000_0099, 0);
    flush = 0;
    chk("flush_tvalid", 64'(m_axis_tvalid), 64'd0);
    chk("flush_level", 64'(fifo_level), 64'd0);
    m_axis_tready = 1;
    send(32'h8000_0051, 0);
    send(32'hC000_0052, 1);
    drain("flush", 1);
    expect_beat("flush_b1", 64'hC000_0052_8000_0051, 1);
    chk("final_pkts", 64'(packets_done), 64'd6);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
